// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: DEPTH-stage MEM->WB pipeline register with stall, flush,
// registered writeback select and a retired-instruction counter.
module mem_wb_pipe_stage #(
   parameter int DATA_W     = 32,
   parameter int CTRL_W     = 6,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 1,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  valid_i,
   input  logic                  syscallFlag_i,
   input  logic [DATA_W-1:0]     memData_i,
   input  logic [DATA_W-1:0]     aluResult_i,
   input  logic [CTRL_W-1:0]     aluCtrl_i,
   input  logic [REG_ADDR_W-1:0] writeReg_i,
   input  logic                  memtoReg_i,
   input  logic                  regWrite_i,
   input  logic                  link_i,
   output logic                  valid_o,
   output logic                  syscallFlag_o,
   output logic [DATA_W-1:0]     memData_o,
   output logic [DATA_W-1:0]     aluResult_o,
   output logic [CTRL_W-1:0]     aluCtrl_o,
   output logic [REG_ADDR_W-1:0] writeReg_o,
   output logic                  memtoReg_o,
   output logic                  regWrite_o,
   output logic                  link_o,
   output logic [DATA_W-1:0]     wbData_o,
   output logic [CNT_W-1:0]      retired_o
);
   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("mem_wb_pipe_stage: DEPTH must be 1..4");
   end
   typedef struct packed {
      logic                  valid;
      logic                  syscall;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic                  link;
      logic [DATA_W-1:0]     mem_data;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     wb_data;
      logic [CTRL_W-1:0]     alu_ctrl;
      logic [REG_ADDR_W-1:0] write_reg;
   } entry_t;
   entry_t            stage_q [DEPTH];
   entry_t            stage_d [DEPTH];
   entry_t            src     [DEPTH];
   entry_t            in_e;
   logic [CNT_W-1:0]  retired_q, retired_d;
   always_comb begin
      in_e            = '0;
      in_e.valid      = valid_i;
      in_e.syscall    = syscallFlag_i & valid_i;
      in_e.mem_to_reg = memtoReg_i & valid_i;
      in_e.reg_write  = regWrite_i & valid_i;
      in_e.link       = link_i & valid_i;
      in_e.mem_data   = memData_i;
      in_e.alu_result = aluResult_i;
      in_e.wb_data    = (memtoReg_i & valid_i) ? memData_i : aluResult_i;
      in_e.alu_ctrl   = aluCtrl_i;
      in_e.write_reg  = writeReg_i;
      src[0] = in_e;
      for (int k = 1; k < DEPTH; k++) src[k] = stage_q[k-1];
      // flush turns every entry into a bubble but keeps its data fields
      for (int k = 0; k < DEPTH; k++) begin
         stage_d[k] = (stall_i || flush_i) ? stage_q[k] : src[k];
         if (flush_i) begin
            stage_d[k].valid      = 1'b0;
            stage_d[k].syscall    = 1'b0;
            stage_d[k].mem_to_reg = 1'b0;
            stage_d[k].reg_write  = 1'b0;
            stage_d[k].link       = 1'b0;
         end
      end
      retired_d = retired_q + CNT_W'(stage_q[DEPTH-1].valid & ~stall_i & ~flush_i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
         retired_q <= '0;
      end else begin
         stage_q   <= stage_d;
         retired_q <= retired_d;
      end
   end
   assign valid_o       = stage_q[DEPTH-1].valid;
   assign syscallFlag_o = stage_q[DEPTH-1].syscall;
   assign memData_o     = stage_q[DEPTH-1].mem_data;
   assign aluResult_o   = stage_q[DEPTH-1].alu_result;
   assign aluCtrl_o     = stage_q[DEPTH-1].alu_ctrl;
   assign writeReg_o    = stage_q[DEPTH-1].write_reg;
   assign memtoReg_o    = stage_q[DEPTH-1].mem_to_reg;
   assign regWrite_o    = stage_q[DEPTH-1].reg_write;
   assign link_o        = stage_q[DEPTH-1].link;
   assign wbData_o      = stage_q[DEPTH-1].wb_data;
   assign retired_o     = retired_q;
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb_mem_wb_pipe_stage: drives a DEPTH=1/CNT_W=4 and a DEPTH=3/CNT_W=32 instance
// with the same stimulus and compares both against a queue-based pipeline model.
module tb_mem_wb_pipe_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic stall_i, flush_i, valid_i, syscallFlag_i, memtoReg_i, regWrite_i, link_i;
   logic [31:0] memData_i, aluResult_i;
   logic [5:0]  aluCtrl_i;
   logic [4:0]  writeReg_i;
   typedef struct packed {
      logic v, s, m, r, l;
      logic [31:0] md, ar, wb;
      logic [5:0] ac;
      logic [4:0] wr;
   } item_t;
   typedef item_t q_t[$];
   logic v1, s1, m1, rw1, l1, v3, s3, m3, rw3, l3;
   logic [31:0] md1, ar1, wb1, md3, ar3, wb3, ret3;
   logic [5:0] ac1, ac3;
   logic [4:0] wr1, wr3;
   logic [3:0] ret1;
   item_t a1, a3;
   assign a1 = {v1, s1, m1, rw1, l1, md1, ar1, wb1, ac1, wr1};
   assign a3 = {v3, s3, m3, rw3, l3, md3, ar3, wb3, ac3, wr3};
   mem_wb_pipe_stage #(.DEPTH(1), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .syscallFlag_i(syscallFlag_i), .memData_i(memData_i), .aluResult_i(aluResult_i),
      .aluCtrl_i(aluCtrl_i), .writeReg_i(writeReg_i), .memtoReg_i(memtoReg_i),
      .regWrite_i(regWrite_i), .link_i(link_i), .valid_o(v1), .syscallFlag_o(s1),
      .memData_o(md1), .aluResult_o(ar1), .aluCtrl_o(ac1), .writeReg_o(wr1),
      .memtoReg_o(m1), .regWrite_o(rw1), .link_o(l1), .wbData_o(wb1), .retired_o(ret1));
   mem_wb_pipe_stage #(.DEPTH(3), .CNT_W(32)) u3 (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .syscallFlag_i(syscallFlag_i), .memData_i(memData_i), .aluResult_i(aluResult_i),
      .aluCtrl_i(aluCtrl_i), .writeReg_i(writeReg_i), .memtoReg_i(memtoReg_i),
      .regWrite_i(regWrite_i), .link_i(link_i), .valid_o(v3), .syscallFlag_o(s3),
      .memData_o(md3), .aluResult_o(ar3), .aluCtrl_o(ac3), .writeReg_o(wr3),
      .memtoReg_o(m3), .regWrite_o(rw3), .link_o(l3), .wbData_o(wb3), .retired_o(ret3));
   q_t q1, q3;
   longint r1, r3;
   int checks = 0, passed = 0;
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   function automatic item_t cur_in();
      item_t it;
      it.v  = valid_i;
      it.s  = syscallFlag_i && valid_i;
      it.m  = memtoReg_i && valid_i;
      it.r  = regWrite_i && valid_i;
      it.l  = link_i && valid_i;
      it.md = memData_i;
      it.ar = aluResult_i;
      it.wb = (memtoReg_i && valid_i) ? memData_i : aluResult_i;
      it.ac = aluCtrl_i;
      it.wr = writeReg_i;
      return it;
   endfunction
   // q[0] is the newest entry, q[$] the one on the outputs
   task automatic adv(inout q_t q, inout longint r, input longint modulus);
      if (!stall_i && !flush_i && q[q.size()-1].v) r = (r + 1) % modulus;
      if (flush_i) begin
         foreach (q[i]) begin
            q[i].v = 0; q[i].s = 0; q[i].m = 0; q[i].r = 0; q[i].l = 0;
         end
      end else if (!stall_i) begin
         q.push_front(cur_in());
         void'(q.pop_back());
      end
   endtask
   task automatic step();
      adv(q1, r1, 16);
      adv(q3, r3, 64'h1_0000_0000);
      @(posedge clk);
      #1;
      check("u1_entry", a1, q1[q1.size()-1]);
      check("u1_retired", ret1, r1);
      check("u3_entry", a3, q3[q3.size()-1]);
      check("u3_retired", ret3, r3);
   endtask
   task automatic set_in(input logic v, input logic st, input logic fl);
      valid_i = v; stall_i = st; flush_i = fl;
      syscallFlag_i = 1'($urandom); memtoReg_i = 1'($urandom);
      regWrite_i = 1'($urandom); link_i = 1'($urandom);
      memData_i = $urandom; aluResult_i = $urandom;
      aluCtrl_i = 6'($urandom); writeReg_i = 5'($urandom);
   endtask
   task automatic do_reset();
      {stall_i, flush_i, valid_i, syscallFlag_i, memtoReg_i, regWrite_i, link_i} = '1;
      memData_i = '1; aluResult_i = '1; aluCtrl_i = '1; writeReg_i = '1;
      rst_n = 1'b0;
      #1;
      check("rst_u1", {a1, ret1}, '0);
      check("rst_u3", {a3, ret3}, '0);
      q1 = {}; q3 = {};
      q1.push_back('0);
      for (int i = 0; i < 3; i++) q3.push_back('0);
      r1 = 0; r3 = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_in(0, 0, 0);
   endtask
   logic [31:0] a_ar, b_ar, c_ar, wb_hold;
   initial begin
      set_in(0, 0, 0);
      @(posedge clk);
      #2;
      do_reset();
      // writeback select with DEPTH=1, then retire one edge later
      set_in(1, 0, 0);
      regWrite_i = 1; memtoReg_i = 1; memData_i = 32'hDEADBEEF; aluResult_i = 32'h10;
      step();
      check("t2_wbdata", wb1, 32'hDEADBEEF);
      check("t2_ret_before", ret1, 4'd0);
      set_in(0, 0, 0);
      step();
      check("t2_ret_after", ret1, 4'd1);
      // DEPTH=3 with a two-cycle stall right after A is captured
      set_in(1, 0, 0); a_ar = aluResult_i;
      step();
      set_in(1, 1, 0); step(); step();
      set_in(1, 0, 0); b_ar = aluResult_i; step();
      check("t3_a_not_yet", v3, 1'b0);
      set_in(1, 0, 0); c_ar = aluResult_i; step();
      check("t3_a_out", {v3, ar3}, {1'b1, a_ar});
      set_in(0, 0, 0); step();
      check("t3_b_out", {v3, ar3}, {1'b1, b_ar});
      step();
      check("t3_c_out", {v3, ar3}, {1'b1, c_ar});
      step();
      check("t3_drained", v3, 1'b0);
      // flush with stall over three valid entries
      for (int i = 0; i < 3; i++) begin set_in(1, 0, 0); step(); end
      wb_hold = wb3;
      b_ar = ret3;
      set_in(1, 1, 1); step();
      check("t4_ctrl_cleared", {v3, rw3, s3}, 3'b000);
      check("t4_wb_held", wb3, wb_hold);
      check("t4_ret_held", ret3, b_ar);
      // invalid entries are gated
      set_in(0, 0, 0); regWrite_i = 1; link_i = 1; writeReg_i = 5'd31;
      step();
      check("t5_gated", {rw1, l1, wr1}, {2'b00, 5'd31});
      b_ar = 32'(ret1);
      set_in(0, 0, 0); step();
      check("t5_no_retire", 32'(ret1), b_ar);
      // counter wrap on the 4-bit instance
      do_reset();
      for (int i = 0; i < 17; i++) begin set_in(1, 0, 0); step(); end
      set_in(0, 0, 0); step();
      check("t6_wrap", ret1, 4'h1);
      // random traffic with a mid-stream reset
      for (int i = 0; i < 300; i++) begin
         if (i == 150) do_reset();
         set_in(1'($urandom_range(0, 3) != 0), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
         step();
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
